param_sync_fifo: RTL and testbench



---
 rtl/param_sync_fifo.sv | 106 ++++++++++
 tb/tb_param_sync_fifo.sv | 128 ++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through; default build gives a registered 1-cycle read latency.
module param_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_LEVEL   = 3,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        write_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        read_en,
  input  logic                        clear_err,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  read_accept_c, write_accept_c;

  // Status is decoded from the count register only, never from pointers.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_CNT);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A pop frees a slot, so a write into a full FIFO succeeds alongside a read.
  assign read_accept_c  = read_en && !empty;
  assign write_accept_c = write_en && (!full || read_accept_c);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = (overflow_q && !clear_err) || (write_en && !write_accept_c);
    underflow_d = (underflow_q && !clear_err) || (read_en && !read_accept_c);
    if (write_accept_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (read_accept_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({write_accept_c, read_accept_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (write_accept_c) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (read_accept_c) data_out_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_out_q <= '0;
    else          data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed table-driven bench for param_sync_fifo (DEPTH=4, AF_LEVEL=3, AE_LEVEL=1).
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       read_en = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset_n(reset_n), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .clear_err(clear_err), .data_out(data_out), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Flags field order: {empty, full, almost_full, almost_empty, overflow, underflow}
  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    logic [2:0] cnt;
    logic [7:0] dout;
    logic [5:0] flg;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

`ifdef FIFO_FWFT_EN
  localparam logic [16:0] MASK = {3'b111, 8'h00, 6'b111111};
`else
  localparam logic [16:0] MASK = {3'b111, 8'hFF, 6'b111111};
`endif

  function automatic logic [16:0] status();
    return {count, data_out, empty, full, almost_full, almost_empty, overflow, underflow};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp,
                       input logic [16:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: got cnt=%0d dout=%h flg=%b, expected cnt=%0d dout=%h flg=%b",
               name, act[16:14], act[13:6], act[5:0], exp[16:14], exp[13:6], exp[5:0]);
    end
  endtask

  task automatic step(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
    write_en = wr; data_in = din; read_en = rd; clear_err = clr;
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    //            wr  din    rd  clr  cnt   dout    E F AF AE O U
    vecs[0]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 3'd1, 8'h00, 6'b000100};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h0A, 6'b100100};
    vecs[2]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 3'd1, 8'h0A, 6'b000100};
    vecs[3]  = '{1'b1, 8'h1B, 1'b0, 1'b0, 3'd2, 8'h0A, 6'b000000};
    vecs[4]  = '{1'b1, 8'h2C, 1'b0, 1'b0, 3'd3, 8'h0A, 6'b001000};
    vecs[5]  = '{1'b1, 8'h3D, 1'b0, 1'b0, 3'd4, 8'h0A, 6'b011000};
    vecs[6]  = '{1'b1, 8'h4E, 1'b0, 1'b0, 3'd4, 8'h0A, 6'b011010};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 8'h0A, 6'b011000};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h0A, 6'b001000};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'h1B, 6'b000000};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h2C, 6'b000100};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h3D, 6'b100100};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h3D, 6'b100101};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h3D, 6'b100100};
    vecs[14] = '{1'b1, 8'h0A, 1'b0, 1'b0, 3'd1, 8'h3D, 6'b000100};
    vecs[15] = '{1'b1, 8'h1B, 1'b0, 1'b0, 3'd2, 8'h3D, 6'b000000};
    vecs[16] = '{1'b1, 8'h2C, 1'b0, 1'b0, 3'd3, 8'h3D, 6'b001000};
    vecs[17] = '{1'b1, 8'h3D, 1'b0, 1'b0, 3'd4, 8'h3D, 6'b011000};
    vecs[18] = '{1'b1, 8'h5F, 1'b1, 1'b0, 3'd4, 8'h0A, 6'b011000};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h1B, 6'b001000};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'h2C, 6'b000000};
    vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h3D, 6'b000100};
    vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h5F, 6'b100100};
    // Empty with read+write: write lands, read rejected, no bypass.
    vecs[23] = '{1'b1, 8'h77, 1'b1, 1'b0, 3'd1, 8'h5F, 6'b000101};
    vecs[24] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h77, 6'b100100};
    // Clear and a fresh underflow on the same edge: set wins.
    vecs[25] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h77, 6'b100101};
    vecs[26] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h77, 6'b100100};

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_state", status(), {3'd0, 8'h00, 6'b100100}, MASK);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr);
      check($sformatf("vec%0d", i), status(), {vecs[i].cnt, vecs[i].dout, vecs[i].flg}, MASK);
    end

    // Async reset mid-cycle with three entries and a pending underflow.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    check("pre_reset", status(), {3'd3, 8'h77, 6'b001001}, MASK);
    #2 reset_n = 1'b0;
    #1 check("async_reset", status(), {3'd0, 8'h00, 6'b100100}, MASK);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("post_reset_wr", status(), {3'd1, 8'h00, 6'b000100}, MASK);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_reset_rd", status(), {3'd0, 8'hA5, 6'b100100}, MASK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
